// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker: sweep state
// encoding and expected truth tables for the common 2-input gates.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Bit k is the expected gate output for input vector k.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle timer: counts the cycles a stimulus vector has been held and flags
// the last one so the checker can move on to sampling.
module settle_timer #(
    parameter int SETTLE_CYCLES = 1,
    localparam int W = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expire = count && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || expire) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Hardware exerciser for an N_IN-input combinational gate: sweeps every input
// vector, holds it SETTLE_CYCLES cycles, then compares dut_out against TRUTH_TABLE.
module gate_truth_table_checker
    import gate_check_pkg::*;
#(
    parameter int                  N_IN          = 2,
    parameter logic [2**N_IN-1:0]  TRUTH_TABLE   = TT_AND2,
    parameter int                  SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2**N_IN-1:0]  fail_vec,
    output logic [N_IN:0]       err_count
);

    localparam int              N_VEC    = 2**N_IN;
    localparam logic [N_IN:0]   LAST_VEC = (N_IN + 1)'(N_VEC - 1);

    state_t         state;
    state_t         next_state;
    logic [N_IN:0]  vec;
    logic           settle_done;
    logic           last_vec;
    logic           restart;
    logic           mismatch;

    assign last_vec = (vec == LAST_VEC);
    assign restart  = start && !abort && (state == IDLE || state == DONE);
    assign mismatch = (state == SAMPLE) && (dut_out != TRUTH_TABLE[vec[N_IN-1:0]]);

    // Held at zero outside DRIVE so every vector starts a fresh settle window.
    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state != DRIVE),
        .count  (state == DRIVE),
        .expire (settle_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) next_state = DRIVE;
                DRIVE:      if (settle_done) next_state = SAMPLE;
                SAMPLE:     next_state = last_vec ? DONE : DRIVE;
                default:    next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state == DRIVE) || (state == SAMPLE);
        done   = (state == DONE);
        pass   = done && (err_count == '0);
        dut_in = busy ? vec[N_IN-1:0] : '0;
    end

    // Vector counter stops on the last vector rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            fail_vec  <= '0;
            err_count <= '0;
        end else if (abort || restart) begin
            vec       <= '0;
            fail_vec  <= '0;
            err_count <= '0;
        end else if (state == SAMPLE) begin
            if (mismatch) begin
                fail_vec[vec[N_IN-1:0]] <= 1'b1;
                err_count               <= err_count + (N_IN + 1)'(1);
            end
            if (!last_vec) begin
                vec <= vec + (N_IN + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: behavioural gates with known truth tables,
// a delayed gate for the settle window, abort, async reset and start-hold cases.
module tb_gate_truth_table_checker;

    logic       clk;
    logic       rst_n;

    logic       start_a, abort_a, dut_out_a, busy_a, done_a, pass_a;
    logic [1:0] dut_in_a;
    logic [3:0] fail_vec_a;
    logic [2:0] err_count_a;

    logic       start_b, abort_b, dut_out_b, busy_b, done_b, pass_b;
    logic [1:0] dut_in_b;
    logic [3:0] fail_vec_b;
    logic [2:0] err_count_b;

    logic [3:0] act_tt;
    logic       use_delay;
    logic [1:0] dly1_a, dly2_a, dly1_b, dly2_b;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0] act_tt;
        logic [3:0] exp_fail;
        logic [2:0] exp_err;
        logic       exp_pass;
    } vec_t;

    vec_t table_vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate stand-ins: a truth-table-driven gate, or an AND gate two cycles late.
    always @(posedge clk) begin
        dly1_a <= dut_in_a;
        dly2_a <= dly1_a;
        dly1_b <= dut_in_b;
        dly2_b <= dly1_b;
    end
    assign dut_out_a = use_delay ? (&dly2_a) : act_tt[dut_in_a];
    assign dut_out_b = &dly2_b;

    gate_truth_table_checker #(
        .N_IN (2), .TRUTH_TABLE (4'b1000), .SETTLE_CYCLES (1)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .start (start_a), .abort (abort_a),
        .dut_in (dut_in_a), .dut_out (dut_out_a), .busy (busy_a), .done (done_a),
        .pass (pass_a), .fail_vec (fail_vec_a), .err_count (err_count_a)
    );

    gate_truth_table_checker #(
        .N_IN (2), .TRUTH_TABLE (4'b1000), .SETTLE_CYCLES (3)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .start (start_b), .abort (abort_b),
        .dut_in (dut_in_b), .dut_out (dut_out_b), .busy (busy_b), .done (done_b),
        .pass (pass_b), .fail_vec (fail_vec_b), .err_count (err_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: a vector fails exactly where the gate's behaviour differs from the table.
    function automatic logic [3:0] ref_fail_vec(input logic [3:0] actual, input logic [3:0] expected);
        logic [3:0] f = '0;
        for (int k = 0; k < 4; k++) f[k] = (actual[k] != expected[k]);
        return f;
    endfunction

    function automatic logic [31:0] snap_a();
        return {busy_a, done_a, pass_a, dut_in_a, fail_vec_a, err_count_a};
    endfunction

    // One full sweep on instance A starting from IDLE or DONE; 8 cycles to DONE.
    task automatic run_sweep_a(input string tag, input logic [3:0] exp_fail, input bit hold_start);
        start_a = 1'b1;
        @(negedge clk);
        if (!hold_start) start_a = 1'b0;
        for (int t = 0; t < 8; t++) begin
            check({tag, "_seq"}, {busy_a, done_a, dut_in_a}, {1'b1, 1'b0, 2'(t / 2)});
            @(negedge clk);
        end
        check({tag, "_done"},      {busy_a, done_a, dut_in_a}, {1'b0, 1'b1, 2'b00});
        check({tag, "_pass"},      pass_a, (exp_fail == 4'b0000));
        check({tag, "_err_count"}, err_count_a, 32'($countones(exp_fail)));
        check({tag, "_fail_vec"},  fail_vec_a, exp_fail);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_f;
        int         cyc;
        bit         found;

        table_vecs[0] = '{4'b1000, 4'b0000, 3'd0, 1'b1};
        table_vecs[1] = '{4'b1110, 4'b0110, 3'd2, 1'b0};
        table_vecs[2] = '{4'b0110, 4'b1110, 3'd3, 1'b0};
        table_vecs[3] = '{4'b0111, 4'b1111, 3'd4, 1'b0};

        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        act_tt = 4'b1000; use_delay = 1'b0;
        #1;
        check("reset_outputs_a", snap_a(), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset_a", snap_a(), 32'd0);
        check("idle_after_reset_b", {busy_b, done_b, pass_b, dut_in_b, fail_vec_b, err_count_b}, 32'd0);

        // Table-driven gate behaviours against the AND table.
        for (int i = 0; i < 4; i++) begin
            act_tt = table_vecs[i].act_tt;
            run_sweep_a($sformatf("table%0d", i), table_vecs[i].exp_fail, 1'b0);
            check($sformatf("table%0d_exp_err", i), err_count_a, table_vecs[i].exp_err);
            check($sformatf("table%0d_exp_pass", i), pass_a, table_vecs[i].exp_pass);
        end

        // Random gate behaviours checked against the reference model.
        for (int i = 0; i < 8; i++) begin
            act_tt = 4'($urandom);
            exp_f  = ref_fail_vec(act_tt, 4'b1000);
            run_sweep_a($sformatf("rand%0d_tt%b", i, act_tt), exp_f, 1'b0);
        end

        // Two-cycle-late AND gate: passes with 3 settle cycles, fails vector 3 with 1.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("settle3_latency", cyc, 16);
        check("settle3_pass", {pass_b, err_count_b, fail_vec_b}, {1'b1, 3'd0, 4'b0000});
        act_tt = 4'b1000;
        use_delay = 1'b1;
        run_sweep_a("settle1_late_gate", 4'b1000, 1'b0);
        use_delay = 1'b0;

        // Abort mid-sweep at vector 2.
        act_tt = 4'b1110;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dut_in_a == 2'd2 && busy_a) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_vec2", found, 1'b1);
        check("abort_partial_fail_vec", fail_vec_a, 4'b0010);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("abort_to_idle", snap_a(), 32'd0);
        abort_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0; start_a = 1'b0;
        check("abort_start_idle", snap_a(), 32'd0);
        run_sweep_a("pre_abort_done", 4'b0110, 1'b0);
        abort_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0; start_a = 1'b0;
        check("abort_start_from_done", snap_a(), 32'd0);

        // Asynchronous reset between edges mid-sweep, then a clean full sweep.
        act_tt = 4'b1000;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mid_sweep", snap_a(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep_a("after_reset", 4'b0000, 1'b0);

        // start held high: no restart while busy, restart from DONE clears results.
        act_tt = 4'b1110;
        run_sweep_a("held_start", 4'b0110, 1'b1);
        @(negedge clk);
        check("held_restart_cleared",
              {busy_a, done_a, dut_in_a, fail_vec_a, err_count_a},
              {1'b1, 1'b0, 2'd0, 4'b0000, 3'd0});
        start_a = 1'b0;
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("final_idle", snap_a(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
